// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: registers the EX payload, waits on data-SRAM read response for loads,
// extracts LB/LBU/LH/LHU/LW data and drives WB and ID-bypass payloads. Optional: MEM_MISALIGN_EXC_EN.
module mem_stage_lsu #(
  parameter int STALL_W     = 6,
  parameter int SIDE_W      = 67,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               ex_valid,
  input  logic [31:0]        ex_pc,
  input  logic               ex_ld,
  input  logic [2:0]         ex_ld_op,
  input  logic               ex_rf_we,
  input  logic [4:0]         ex_rf_waddr,
  input  logic [31:0]        ex_result,
  input  logic [SIDE_W-1:0]  ex_side,
  input  logic               data_sram_rvalid,
  input  logic [31:0]        data_sram_rdata,
  output logic               stallreq_mem,
  output logic               bus_err,
  output logic               wb_valid,
  output logic [31:0]        wb_pc,
  output logic               wb_rf_we,
  output logic [4:0]         wb_rf_waddr,
  output logic [31:0]        wb_rf_wdata,
  output logic [SIDE_W-1:0]  wb_side,
  output logic               fwd_we,
  output logic [4:0]         fwd_waddr,
  output logic [31:0]        fwd_wdata,
`ifdef MEM_MISALIGN_EXC_EN
  output logic               misalign_exc,
`endif
  output logic               fwd_pending
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         buf_q, buf_d;
  logic                bus_err_q, bus_err_d;

  logic                valid_q;
  logic [31:0]         pc_q;
  logic                ld_q;
  logic [2:0]          ld_op_q;
  logic                rf_we_q;
  logic [4:0]          waddr_q;
  logic [31:0]         result_q;
  logic [SIDE_W-1:0]   side_q;

  logic capture, bubble, ld_r, mis_r, mis_ex, new_ld, busy;
  logic unused_stall;

  assign capture      = ~stall[3];
  assign bubble       = stall[3] & ~stall[4];
  assign unused_stall = ^stall;

  function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] a,
                                          input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*a +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (op)
      3'b001:  return {{24{b[7]}}, b};
      3'b010:  return {24'h0, b};
      3'b011:  return {{16{h[15]}}, h};
      3'b100:  return {16'h0, h};
      default: return d;
    endcase
  endfunction

`ifdef MEM_MISALIGN_EXC_EN
  // Byte ops are always aligned; unknown op codes behave as LW.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      3'b001, 3'b010: return 1'b0;
      3'b011, 3'b100: return a[0];
      default:        return a != 2'b00;
    endcase
  endfunction

  assign mis_r        = valid_q & ld_q & misaligned(ld_op_q, result_q[1:0]);
  assign mis_ex       = ex_valid & ex_ld & misaligned(ex_ld_op, ex_result[1:0]);
  assign misalign_exc = mis_r;
`else
  assign mis_r  = 1'b0;
  assign mis_ex = 1'b0;
`endif

  assign ld_r   = valid_q & ld_q;
  assign new_ld = ex_valid & ex_ld & ~mis_ex;
  assign busy   = ld_r & ~mis_r & (state_q != S_DONE);

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      ld_q     <= 1'b0;
      ld_op_q  <= '0;
      rf_we_q  <= 1'b0;
      waddr_q  <= '0;
      result_q <= '0;
      side_q   <= '0;
    end else if (capture) begin
      valid_q  <= ex_valid;
      pc_q     <= ex_pc;
      ld_q     <= ex_ld;
      ld_op_q  <= ex_ld_op;
      rf_we_q  <= ex_rf_we;
      waddr_q  <= ex_rf_waddr;
      result_q <= ex_result;
      side_q   <= ex_side;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      buf_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    bus_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_r && !mis_r) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (ld_r && mis_r) begin
          // A misaligned load completes at once; a same-cycle capture replaces it.
          buf_d = '0;
          if (capture)     state_d = new_ld ? S_WAIT : S_IDLE;
          else if (bubble) state_d = S_IDLE;
          else             state_d = S_DONE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (data_sram_rvalid) begin
          buf_d   = extract(ld_op_q, result_q[1:0], data_sram_rdata);
          state_d = S_DONE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          buf_d     = '0;
          bus_err_d = 1'b1;
          state_d   = S_DONE;
          cnt_d     = '0;
        end
      end
      S_DONE: begin
        if (capture)     state_d = new_ld ? S_WAIT : S_IDLE;
        else if (bubble) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stallreq_mem = busy;
  assign fwd_pending  = busy;
  assign bus_err      = bus_err_q;
  assign wb_valid     = valid_q & ~busy;
  assign wb_pc        = pc_q;
  assign wb_rf_we     = rf_we_q & ~mis_r;
  assign wb_rf_waddr  = waddr_q;
  assign wb_rf_wdata  = ld_q ? (mis_r ? 32'h0 : buf_q) : result_q;
  assign wb_side      = side_q;
  assign fwd_we       = wb_rf_we;
  assign fwd_waddr    = waddr_q;
  assign fwd_wdata    = wb_rf_wdata;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Next-generation MEM pipeline stage between EX and WB.
- Registers the EX payload under the global stall bus and waits a variable number of cycles for the data-SRAM read response using a valid handshake. It raises a stall request while waiting.
- Extracts byte and halfword load data (LB/LBU/LH/LHU/LW).
- Drives the WB payload and the ID bypass payload, with a pending flag for load-use hazards.

Parameters:
- STALL_W, 6, width of the global stall bus; this stage uses bits 3 (self) and 4 (WB).
- SIDE_W, 67, opaque sideband width carried unchanged EX→WB→ID (hi/lo, div result, flags).
- TIMEOUT_CYC, 255, maximum wait cycles for a load response before a forced completion.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  STALL_W  global stall bus; 1 = Stop
- ex_valid  in  1  EX payload is a real instruction
- ex_pc  in  32  instruction PC
- ex_ld  in  1  instruction is a load
- ex_ld_op  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; other codes decode as LW
- ex_rf_we  in  1  register write enable
- ex_rf_waddr  in  5  destination register
- ex_result  in  32  ALU result or effective address
- ex_side  in  SIDE_W  sideband
- data_sram_rvalid  in  1  read data valid, one-cycle pulse
- data_sram_rdata  in  32  read data
- stallreq_mem  out  1  MEM requests a pipeline stall
- bus_err  out  1  one-cycle pulse on load timeout
- wb_valid  out  1  WB payload valid
- wb_pc  out  32  PC to WB
- wb_rf_we  out  1  register write enable to WB
- wb_rf_waddr  out  5  destination register to WB
- wb_rf_wdata  out  32  write data to WB
- wb_side  out  SIDE_W  sideband to WB
- fwd_we  out  1  bypass write enable to ID
- fwd_waddr  out  5  bypass destination register to ID
- fwd_wdata  out  32  bypass write data to ID
- fwd_pending  out  1  bypass data is not yet valid (load outstanding)

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset:
  - Input register cleared.
  - State IDLE, timeout counter 0, data buffer 0.
  - All outputs 0.
- Input register capture:
  - rst → clear.
  - Else if stall[3]=Stop and stall[4]=NoStop → load a bubble (all fields 0).
  - Else if stall[3]=NoStop → capture the ex_* fields.
  - Else → hold.
- FSM states IDLE, WAIT, DONE:
  - IDLE: if the registered instruction is a valid load, the next state is WAIT.
  - WAIT:
    - stallreq_mem=1 and the counter increments.
    - On data_sram_rvalid: capture the extracted data into the buffer and go to DONE.
    - If the counter reaches TIMEOUT_CYC first: buffer=0, bus_err=1 for one cycle, go to DONE.
  - DONE: stallreq_mem=0. Stay in DONE until a new payload is captured (stall[3]=NoStop), then go to IDLE, or straight to WAIT if the new payload is a load.
  - WAIT→DONE and a new capture never occur in the same cycle, because stallreq holds stall[3].
  - rvalid in any state other than WAIT is ignored.
  - rvalid arriving in the same cycle as the timeout: rvalid wins and bus_err stays 0.
- Load data latency: at least one cycle after the register capture. stallreq_mem is combinationally 1 in the capture-follow cycle for a load, i.e. it is asserted whenever a load is registered and state≠DONE.
- Extraction, with a = ex_result[1:0]:
  - LB / LBU: byte at lane a, sign- or zero-extended.
  - LH / LHU: halfword at a[1], sign- or zero-extended.
  - LW: full word.
- wb_rf_wdata = buffer if the instruction is a load, else ex_result.
- wb_valid = registered valid and not (load and state≠DONE). All other wb_* fields pass through the register.
- Bypass payload:
  - fwd_we = rf_we, fwd_waddr = rf_waddr, fwd_wdata = wb_rf_wdata.
  - fwd_pending = 1 while a load is registered and state≠DONE.
- Downstream hold (stall[4]=Stop) while in DONE: buffer and outputs held stable.

Optional Feature:
- Macro MEM_MISALIGN_EXC_EN.
- Defined:
  - An LH/LHU with a[0]=1, or an LW with a≠0, does not enter WAIT.
  - It goes directly to DONE with buffer=0 and rf_we forced to 0 toward WB and ID.
  - Adds output misalign_exc (1 bit), which equals 1 while that instruction is in DONE and the stage is registered.
- Undefined: no check is made, the address low bits are ignored for LW, a[0] is ignored for halfwords, and the misalign_exc port is absent.

Test Plan:
- Reset: assert rst for 2 cycles → all outputs 0, state IDLE, stallreq_mem=0.
- ALU op: ex_result=0x12345678, rf_we=1, waddr=5, no load → next cycle wb_valid=1, wb_rf_wdata=0x12345678, fwd_pending=0, no stall.
- LB with a=3, rdata=0x80FF00AA, rvalid after 3 cycles → stallreq_mem=1 for 3 cycles, then wb_rf_wdata=0xFFFFFF80. The same case as LBU gives 0x00000080.
- LHU with a=2, rdata=0xBEEF1234, rvalid during a stall[4]=Stop hold → buffer holds 0x0000BEEF across the hold, and wb_valid rises once the hold releases.
- Timeout: a load with no rvalid → after TIMEOUT_CYC cycles, bus_err pulses once, wb_rf_wdata=0, and stallreq_mem drops. A late rvalid arriving afterwards is ignored.
- With MEM_MISALIGN_EXC_EN: LW with a=2 → no stall, misalign_exc=1, wb_rf_we=0.
